// File: rtl/d2s_conv_arbiter_pkg.sv
// Shared constants, types and conversion helpers for the double-to-s16 arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
package d2s_conv_arbiter_pkg;

  // Exponent thresholds of the IEEE-754 double
  localparam logic [10:0] DBL_BIAS       = 11'd1023;
  localparam logic [10:0] DBL_EXP_SAT    = 11'd1038;
  // {1,m} must be right-shifted by 52-(e-1023) = 1075-e
  localparam logic [10:0] DBL_SHIFT_BASE = 11'd1075;
  localparam logic [14:0] S16_MAG_MAX    = 15'h7FFF;

  // Field positions inside the double
  localparam int DBL_SIGN_BIT = 63;
  localparam int DBL_EXP_MSB  = 62;
  localparam int DBL_EXP_LSB  = 52;
  localparam int DBL_MANT_MSB = 51;
  localparam int DBL_MANT_LSB = 0;

  // Sign-magnitude result with saturation flag
  typedef struct packed {
    logic        sat;
    logic        sign;
    logic [14:0] mag;
  } res_t;

  // Classified operand carried between the first and last pipeline stages
  typedef struct packed {
    logic        sign;
    logic        zero;   // |x| < 1
    logic        sat;    // |x| >= 32768, Inf, NaN
    logic [51:0] mant;
    logic [5:0]  shift;  // valid only when neither zero nor sat
  } cls_t;

  function automatic cls_t dbl_classify(input logic [63:0] dbl);
    cls_t        c;
    logic [10:0] e;
    e       = dbl[DBL_EXP_MSB:DBL_EXP_LSB];
    c.sign  = dbl[DBL_SIGN_BIT];
    c.zero  = (e < DBL_BIAS);
    c.sat   = (e >= DBL_EXP_SAT);
    c.mant  = dbl[DBL_MANT_MSB:DBL_MANT_LSB];
    // Wraps for out-of-range exponents; those cases are overridden by zero/sat.
    c.shift = 6'(DBL_SHIFT_BASE - e);
    return c;
  endfunction

  function automatic res_t dbl_finish(input cls_t c);
    res_t r;
    r.sat = c.sat;
    if (c.sat) begin
      r.mag = S16_MAG_MAX;
    end else if (c.zero) begin
      r.mag = '0;
    end else begin
      r.mag = 15'({1'b1, c.mant} >> c.shift);
    end
    // No negative zero
    r.sign = c.sign & (r.mag != '0);
    return r;
  endfunction

endpackage

// File: rtl/d2s_conv_arbiter_pipe.sv
// Pipelined double -> 16-bit sign-magnitude converter carrying a channel tag.
// Latency: LAT cycles from i_valid to o_valid (stage 1 classifies, last stage shifts).
// Backpressure: none; the pipeline advances every cycle.
// Ports: clk/rst; i_valid, i_tag, i_dbl in; o_valid, o_tag, o_res out (o_tag/o_res hold when idle).
module dbl2s16_pipe
  import d2s_conv_arbiter_pkg::*;
#(
  parameter int LAT = 2,
  parameter int TW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [TW-1:0] i_tag,
  input  logic [63:0]   i_dbl,
  output logic          o_valid,
  output logic [TW-1:0] o_tag,
  output res_t          o_res
);

  cls_t          w_cls;
  logic          r_vld_q;
  logic [TW-1:0] r_tag_q;
  res_t          r_res_q;

  assign w_cls = dbl_classify(i_dbl);

  generate
    if (LAT == 1) begin : g_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld_q <= 1'b0;
          r_tag_q <= '0;
          r_res_q <= '0;
        end else begin
          r_vld_q <= i_valid;
          if (i_valid) begin
            r_tag_q <= i_tag;
            r_res_q <= dbl_finish(w_cls);
          end
        end
      end
    end else begin : g_multi
      logic          r_vld [LAT-1];
      logic [TW-1:0] r_tag [LAT-1];
      cls_t          r_cls [LAT-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < LAT-1; k++) begin
            r_vld[k] <= 1'b0;
            r_tag[k] <= '0;
            r_cls[k] <= '0;
          end
          r_vld_q <= 1'b0;
          r_tag_q <= '0;
          r_res_q <= '0;
        end else begin
          r_vld[0] <= i_valid;
          if (i_valid) begin
            r_tag[0] <= i_tag;
            r_cls[0] <= w_cls;
          end
          // Optional pure-delay stages between classify and shift
          for (int k = 1; k < LAT-1; k++) begin
            r_vld[k] <= r_vld[k-1];
            if (r_vld[k-1]) begin
              r_tag[k] <= r_tag[k-1];
              r_cls[k] <= r_cls[k-1];
            end
          end
          r_vld_q <= r_vld[LAT-2];
          if (r_vld[LAT-2]) begin
            r_tag_q <= r_tag[LAT-2];
            r_res_q <= dbl_finish(r_cls[LAT-2]);
          end
        end
      end
    end
  endgenerate

  assign o_valid = r_vld_q;
  assign o_tag   = r_tag_q;
  assign o_res   = r_res_q;

endmodule

// File: rtl/d2s_conv_arbiter.sv
// Round-robin arbiter sharing one double -> s16 converter among N requesters.
// Latency: LAT cycles from acceptance (req_valid & req_ready) to out_valid.
// Backpressure: grants one requester per cycle; no output backpressure.
// Ports: clk, rst (async, high); req_valid/req_data/req_ready per channel; ch_enable mask;
//        out_valid/out_ch/out_data/out_sat result; sat_count with synchronous sat_clr.
module d2s_conv_arbiter
  import d2s_conv_arbiter_pkg::*;
#(
  parameter int N   = 3,
  parameter int LAT = 2,
  parameter int CHW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [N*64-1:0]   req_data,
  output logic [N-1:0]      req_ready,
  input  logic [N-1:0]      ch_enable,
  output logic              out_valid,
  output logic [CHW-1:0]    out_ch,
  output logic [15:0]       out_data,
  output logic              out_sat,
  output logic [15:0]       sat_count,
  input  logic              sat_clr
);

  logic [CHW-1:0] r_ptr;
  logic [15:0]    r_sat_cnt;

  logic [N-1:0]   w_elig;
  logic [N-1:0]   w_grant;
  logic           w_acc;
  logic [CHW-1:0] w_gnt_idx;
  logic [63:0]    w_gnt_dat;

  logic           w_pipe_vld;
  logic [CHW-1:0] w_pipe_tag;
  res_t           w_pipe_res;

  assign w_elig = req_valid & ch_enable;

  // Search from the pointer, wrapping modulo N; first eligible channel wins.
  always_comb begin
    int j;
    w_grant   = '0;
    w_acc     = 1'b0;
    w_gnt_idx = '0;
    w_gnt_dat = '0;
    j         = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (!rst && !w_acc && w_elig[j]) begin
        w_acc      = 1'b1;
        w_grant[j] = 1'b1;
        w_gnt_idx  = CHW'(j);
        w_gnt_dat  = req_data[64*j +: 64];
      end
    end
  end

  assign req_ready = w_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_acc) begin
      r_ptr <= (w_gnt_idx == CHW'(N-1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  dbl2s16_pipe #(
    .LAT (LAT),
    .TW  (CHW)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_acc),
    .i_tag   (w_gnt_idx),
    .i_dbl   (w_gnt_dat),
    .o_valid (w_pipe_vld),
    .o_tag   (w_pipe_tag),
    .o_res   (w_pipe_res)
  );

  // Clear wins over a simultaneous increment; count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (sat_clr) begin
      r_sat_cnt <= '0;
    end else if (w_pipe_vld && w_pipe_res.sat && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign out_valid = w_pipe_vld;
  assign out_ch    = w_pipe_tag;
  assign out_data  = {w_pipe_res.sign, w_pipe_res.mag};
  assign out_sat   = w_pipe_res.sat;
  assign sat_count = r_sat_cnt;

endmodule

// File: tb/tb_d2s_conv_arbiter.sv
module tb_d2s_conv_arbiter;

  localparam int N   = 3;
  localparam int LAT = 2;
  localparam int CHW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*64-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      ch_enable;
  logic              out_valid;
  logic [CHW-1:0]    out_ch;
  logic [15:0]       out_data;
  logic              out_sat;
  logic [15:0]       sat_count;
  logic              sat_clr;

  d2s_conv_arbiter #(.N(N), .LAT(LAT), .CHW(CHW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .ch_enable (ch_enable),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_count (sat_count),
    .sat_clr   (sat_clr)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int             due;
    logic [CHW-1:0] ch;
    logic [15:0]    data;
    logic           sat;
  } exp_t;

  exp_t           q[$];
  int             m_ptr;
  int             cyc;
  logic [15:0]    m_cnt;
  logic [15:0]    m_data;
  logic [CHW-1:0] m_ch;
  logic           m_sat;
  logic [N-1:0]   refill;
  logic [N-1:0]   last_ready;
  logic           last_ov;
  logic [CHW-1:0] last_och;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference conversion from real arithmetic: {sat, sign, mag[14:0]}
  function automatic logic [16:0] ref_conv(input logic [63:0] d);
    real x;
    real ax;
    int  mag;
    x  = $bitstoreal(d);
    ax = (x < 0.0) ? -x : x;
    if (!(ax < 32768.0)) return {1'b1, d[63], 15'h7FFF};
    mag = $rtoi(ax);
    return {1'b0, (d[63] && mag != 0), 15'(mag)};
  endfunction

  function automatic logic [63:0] rand_dbl();
    logic [63:0] r;
    logic [10:0] e;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 9))
      0: r[62:52] = 11'h7FF;
      1: r[62:52] = 11'h000;
      2: r[62:0]  = '0;
      default: begin
        e = 11'(1015 + $urandom_range(0, 30));
        r[62:52] = e;
      end
    endcase
    return r;
  endfunction

  task automatic clear_model();
    q.delete();
    m_ptr  = 0;
    m_cnt  = '0;
    m_data = '0;
    m_ch   = '0;
    m_sat  = 1'b0;
  endtask

  // One clock: check at negedge against the model, advance model, drive after posedge.
  task automatic cycle();
    logic [N-1:0] eg;
    logic [16:0]  r;
    int           g;
    int           j;
    logic         emit_sat;
    @(negedge clk);
    eg = '0;
    g  = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (g < 0 && req_valid[j] && ch_enable[j]) g = j;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    chk("req_ready", req_ready, eg);
    last_ready = req_ready;
    last_ov    = out_valid;
    last_och   = out_ch;
    emit_sat   = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("out_valid", out_valid, 1);
      chk("out_ch", out_ch, q[0].ch);
      chk("out_data", out_data, q[0].data);
      chk("out_sat", out_sat, q[0].sat);
      m_ch     = q[0].ch;
      m_data   = q[0].data;
      m_sat    = q[0].sat;
      emit_sat = q[0].sat;
      void'(q.pop_front());
    end else begin
      chk("out_valid_idle", out_valid, 0);
      chk("out_ch_hold", out_ch, m_ch);
      chk("out_data_hold", out_data, m_data);
      chk("out_sat_hold", out_sat, m_sat);
    end
    chk("sat_count", sat_count, m_cnt);
    if (!rst) begin
      if (g >= 0) begin
        r = ref_conv(req_data[64*g +: 64]);
        q.push_back('{due: cyc + LAT, ch: CHW'(g), data: r[15:0], sat: r[16]});
        m_ptr = (g + 1) % N;
      end
      if (sat_clr) m_cnt = '0;
      else if (emit_sat && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    cyc++;
    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (refill[g]) req_data[64*g +: 64] = rand_dbl();
      else           req_valid[g] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic send_one(input int ch, input logic [63:0] d);
    int n;
    n = 0;
    req_data[64*ch +: 64] = d;
    req_valid[ch] = 1'b1;
    refill[ch]    = 1'b0;
    while (req_valid[ch] && n < 8) begin
      cycle();
      n++;
    end
    chk("send_timeout", req_valid[ch], 0);
    chk("accept_same_cycle", n, 1);
    repeat (LAT + 1) cycle();
  endtask

  initial begin
    logic [N-1:0]   eg;
    logic [CHW-1:0] ec;
    logic           seen;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    ch_enable = '1;
    sat_clr   = 1'b0;
    refill    = '0;
    cyc       = 0;
    clear_model();

    // Reset state
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_sat_count", sat_count, 16'h0000);

    // Directed conversions
    send_one(0, 64'h4008000000000000);
    chk("d3_data", out_data, 16'h0003);
    chk("d3_ch", out_ch, 0);
    chk("d3_sat", out_sat, 0);
    send_one(1, 64'hC0C3880000000000);
    chk("dm10000_data", out_data, 16'hA710);
    chk("dm10000_ch", out_ch, 1);
    send_one(2, 64'h3FE0000000000000);
    chk("dhalf_data", out_data, 16'h0000);
    chk("dhalf_ch", out_ch, 2);
    send_one(2, 64'hBFE0000000000000);
    chk("dmhalf_data", out_data, 16'h0000);
    send_one(0, 64'h40E0000000000000);
    chk("d32768_data", out_data, 16'h7FFF);
    chk("d32768_sat", out_sat, 1);
    chk("d32768_cnt", sat_count, 16'd1);
    send_one(1, 64'hFFF0000000000000);
    chk("dninf_data", out_data, 16'hFFFF);
    chk("dninf_sat", out_sat, 1);
    chk("dninf_cnt", sat_count, 16'd2);
    send_one(2, 64'h40DFFFC000000000);
    chk("d32767_data", out_data, 16'h7FFF);
    chk("d32767_sat", out_sat, 0);
    chk("d32767_cnt", sat_count, 16'd2);

    // sat_clr in the same cycle as a saturating result
    req_data[63:0] = 64'h40E0000000000000;
    req_valid[0]   = 1'b1;
    cycle();
    cycle();
    sat_clr = 1'b1;
    cycle();
    chk("clr_emit_sat", out_sat, 1);
    sat_clr = 1'b0;
    cycle();
    chk("clr_priority", sat_count, 16'd0);

    send_one(0, 64'h40E0000000000000);
    chk("pre_rst_cnt", sat_count, 16'd1);

    // Reset raised just after the second acceptance edge
    req_data[63:0]   = 64'h40E0000000000000;
    req_data[127:64] = 64'hC0E0000000000000;
    req_valid        = 3'b011;
    cycle();
    cycle();
    do_reset();
    repeat (LAT + 2) begin
      cycle();
      chk("rst_no_late_pulse", last_ov, 0);
    end
    chk("rst_cnt_zero", sat_count, 16'd0);
    req_valid = '1;
    refill    = '1;
    cycle();
    chk("rst_ptr_zero", last_ready, 3'b001);

    // Continuous requests from reset: strict rotation with no output gaps
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle();
      eg = N'(1 << (i % N));
      chk("rr_grant", last_ready, eg);
      if (i >= LAT) begin
        ec = CHW'((i - LAT) % N);
        chk("rr_out_valid", last_ov, 1);
        chk("rr_out_ch", last_och, ec);
      end
    end

    // Masked channel 1
    ch_enable = 3'b101;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle();
      eg = (i % 2 == 0) ? 3'b001 : 3'b100;
      chk("mask_grant", last_ready, eg);
    end
    ch_enable = '1;
    seen = 1'b0;
    for (int i = 0; i < N; i++) begin
      cycle();
      if (last_ready[1]) seen = 1'b1;
    end
    chk("reenable_ch1", seen, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if (!req_valid[c] && $urandom_range(0, 2) == 0) begin
          req_valid[c] = 1'b1;
          req_data[64*c +: 64] = rand_dbl();
        end else if (req_valid[c] && $urandom_range(0, 15) == 0) begin
          req_valid[c] = 1'b0;
        end
      end
      ch_enable = ($urandom_range(0, 7) == 0) ? N'($urandom()) : '1;
      sat_clr   = ($urandom_range(0, 19) == 0);
      cycle();
    end
    req_valid = '0;
    sat_clr   = 1'b0;
    repeat (LAT + 2) cycle();
    chk("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/d2s_conv_arbiter.md
Name: d2s_conv_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one pipelined double-precision to 16-bit sign-magnitude converter among N requesters in the echo-cancellation datapath.
- Typical requesters: filter output, echo estimate and error signal.
- Each requester offers a 64-bit IEEE-754 double with a valid/ready handshake.
- Results emerge in acceptance order, tagged with the channel index, plus saturation status and a running saturation count.

Parameters:
N, 3, number of requesters (2..8)
LAT, 2, converter pipeline depth in cycles from acceptance to out_valid (1..4)
CHW, 2, channel tag width, ceil(log2(N)), minimum 1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  N  per-channel request valid
req_data  input  N*64  per-channel double; channel i occupies bits [64*i+63:64*i]
req_ready  output  N  one-hot grant, combinational from req_valid, ch_enable and the priority pointer
ch_enable  input  N  channel mask; a disabled channel is never granted
out_valid  output  1  result valid, single-cycle pulse per accepted request
out_ch  output  CHW  channel index of the current result
out_data  output  16  [15] sign, [14:0] magnitude
out_sat  output  1  current result was saturated
sat_count  output  16  saturating count of saturated results
sat_clr  input  1  synchronous clear of sat_count

Behaviour:
- Reset (async, immediate): out_valid=0, out_ch=0, out_data=0, out_sat=0, sat_count=0, pointer=0, all pipeline valid bits cleared.
- In-flight conversions at reset are dropped, never emitted.
- req_ready is 0 while rst is high.
- Arbitration:
  - At most one grant per cycle.
  - Search starts at the pointer and wraps modulo N; the first i with req_valid[i] & ch_enable[i] gets req_ready[i]=1.
  - On acceptance (valid & ready), pointer <= (i+1) mod N. With no acceptance, the pointer holds.
- Handshake:
  - A requester holds req_valid and req_data stable until accepted.
  - Dropping req_valid before acceptance is legal; no grant results.
  - No output backpressure; the pipeline always advances, so throughput is 1 conversion per cycle.
- Latency: data accepted in cycle t produces out_valid=1 in cycle t+LAT, with the matching out_ch/out_data/out_sat.
- out_data, out_ch and out_sat hold their last values when out_valid=0.
- Conversion (e = double[62:52], m = double[51:0]):
  - e<1023 (|x|<1, including zero and denormals): magnitude=0.
  - 1023<=e<=1037: magnitude = floor(1.m * 2^(e-1023)), i.e. truncation toward zero. This is {1,m} right-shifted by 52-(e-1023).
  - e>=1038 (|x|>=32768, including Inf and NaN): magnitude=0x7FFF, out_sat=1.
  - Sign = double[63]. If magnitude is 0, the sign is forced to 0; no negative zero is emitted.
- sat_count:
  - Increments by 1 on each out_valid with out_sat=1, and sticks at 0xFFFF.
  - sat_clr sets it to 0 and takes priority over a simultaneous increment.
- ch_enable changes take effect in the same cycle's grant.
- Results already in the pipeline still complete even if their channel has since been disabled.

Decomposition:
- Shared package:
  - Constants: DBL_BIAS=1023, DBL_EXP_SAT=1038, S16_MAG_MAX=15'h7FFF.
  - Field-position constants for sign, exponent and mantissa of the double.
  - Packed result typedef {sat, sign, mag[14:0]}.
- One natural sub-module: dbl2s16_pipe.
  - Inputs: valid, tag and double. Outputs: valid, tag, sign-magnitude result and sat flag after LAT registered stages.
  - Stage 1 classifies the exponent and computes the shift; the last stage shifts and registers.
- The arbiter (pointer, grant logic) and sat_count live in d2s_conv_arbiter.

Test Plan:
- Single channel 0 sends 0x4008000000000000 (3.0) -> req_ready[0] the same cycle; LAT cycles later out_valid=1, out_ch=0, out_data=0x0003, out_sat=0.
- Channel 1 sends 0xC0C3880000000000 (-10000.0) -> out_data=0x8000|10000=0xA710, out_sat=0. Channel 2 sends 0x3FE0000000000000 (0.5) -> out_data=0x0000, sign forced 0. Channel 2 sends 0xBFE0000000000000 (-0.5) -> out_data=0x0000, sign forced 0.
- Saturation:
  - 0x40E0000000000000 (32768.0) -> out_data=0x7FFF, out_sat=1, sat_count=1.
  - 0xFFF0000000000000 (-Inf) -> out_data=0xFFFF, out_sat=1, sat_count=2.
  - 0x40DFFFC000000000 (32767.0) -> out_data=0x7FFF, out_sat=0, sat_count unchanged.
- All three channels hold req_valid continuously from reset -> grants 0,1,2,0,1,2 on consecutive cycles; out_ch follows the same sequence LAT cycles later with no gaps.
- ch_enable=3'b101 with all channels requesting -> grants alternate 0,2,0,2; channel 1 is never granted. Re-enabling channel 1 makes it granted within N cycles.
- Assert rst with 2 conversions in flight -> out_valid stays 0 with no late pulses, pointer returns to 0, and sat_count=0. Also check sat_clr coinciding with a saturating result -> sat_count=0.
